// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl -- sequencing controller between the EX stage and the iterative
// divider for DIV/DIVU.
//
// The controller takes a division request from EX and holds the pipeline in a
// stall. It latches the operands and sign mode for the divider and captures
// the {remainder, quotient} result into HI/LO. It then pulses a one-cycle
// HI/LO write strobe. On a flush it aborts the divider for a fixed three-cycle
// window.
//
// Ports
//   clk            in   1        clock, rising edge
//   rst            in   1        asynchronous active-low reset
//   div_req_i      in   1        EX holds a valid DIV/DIVU
//   div_signed_i   in   1        1 = DIV, 0 = DIVU
//   op1_i, op2_i   in   DATA_W   dividend / divisor from EX
//   flush_i        in   1        pipeline flush / exception
//   stall_o        out  1        stall request (combinational)
//   div_start_o    out  1        start request to divider (registered)
//   div_signed_o   out  1        latched sign mode to divider
//   div_discard_o  out  1        abort request to divider (registered)
//   div_op1_o/op2_o out DATA_W   latched operands to divider
//   div_result_i   in   2*DATA_W {remainder, quotient}
//   div_ready_i    in   1        divider result valid
//   hi_o, lo_o     out  DATA_W   remainder / quotient for HI/LO
//   hilo_we_o      out  1        one-cycle HI/LO write strobe
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_req_i,
    input  logic                  div_signed_i,
    input  logic [DATA_W-1:0]     op1_i,
    input  logic [DATA_W-1:0]     op2_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  div_start_o,
    output logic                  div_signed_o,
    output logic                  div_discard_o,
    output logic [DATA_W-1:0]     div_op1_o,
    output logic [DATA_W-1:0]     div_op2_o,
    input  logic [2*DATA_W-1:0]   div_result_i,
    input  logic                  div_ready_i,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  hilo_we_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_DONE   = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    // Last CANCEL cycle: counter runs 0,1,2 for three cycles of discard.
    localparam logic [1:0] CANCEL_LAST = 2'd2;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_cnt;
    logic                r_start;
    logic                r_discard;
    logic                r_signed;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_accept;
    logic                w_capture;
    logic                w_stall;
    logic                w_hilo_we;

    // Next-state and combinational outputs.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_stall   = 1'b0;
        w_hilo_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = div_req_i & ~flush_i;
                if (div_req_i && !flush_i) begin
                    w_accept = 1'b1;
                    w_next   = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                // A flush wins over a simultaneous ready: the result is dropped.
                if (flush_i) begin
                    w_next = S_CANCEL;
                end else if (div_ready_i) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_hilo_we = ~flush_i;
                w_next    = S_IDLE;
            end
            S_CANCEL: begin
                // The next instruction may already be waiting in EX.
                w_stall = div_req_i;
                if (r_cnt == CANCEL_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, cancel counter and registered divider handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_start   <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == S_CANCEL && w_next == S_CANCEL) ? r_cnt + 2'd1 : 2'd0;
            r_start   <= (w_next == S_BUSY);
            r_discard <= (w_next == S_CANCEL);
        end
    end

    // Operand/sign latch: held for all of BUSY since the divider re-reads
    // them during its sign-fix step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_op1    <= op1_i;
            r_op2    <= op2_i;
            r_signed <= div_signed_i;
        end
    end

    // HI/LO capture; values hold until the next completed division.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= div_result_i[2*DATA_W-1:DATA_W];
            r_lo <= div_result_i[DATA_W-1:0];
        end
    end

    // Stall is gated by reset so every output reads 0 while rst is low.
    assign stall_o       = w_stall & rst;
    assign hilo_we_o     = w_hilo_we;
    assign div_start_o   = r_start;
    assign div_discard_o = r_discard;
    assign div_signed_o  = r_signed;
    assign div_op1_o     = r_op1;
    assign div_op2_o     = r_op2;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl -- directed testbench for div_ctrl.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
// The divider is stood in for by hand-computed result vectors.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        div_req_i;
    logic        div_signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        flush_i;
    logic        stall_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic        div_discard_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        hilo_we_o;

    int checks = 0;
    int errors = 0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_req_i     (div_req_i),
        .div_signed_i  (div_signed_i),
        .op1_i         (op1_i),
        .op2_i         (op2_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .div_start_o   (div_start_o),
        .div_signed_o  (div_signed_o),
        .div_discard_o (div_discard_o),
        .div_op1_o     (div_op1_o),
        .div_op2_o     (div_op2_o),
        .div_result_i  (div_result_i),
        .div_ready_i   (div_ready_i),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .hilo_we_o     (hilo_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full division: request in cycle 0, ready in cycle rdy, DONE in rdy+1.
    // EX-side operands are scrambled during BUSY to prove the latch holds.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int rdy, input logic [63:0] res,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic done_flush);
        int stalls;
        int wes;
        stalls = 0;
        wes    = 0;
        @(negedge clk);
        div_req_i = 1'b1; op1_i = a; op2_i = b; div_signed_i = s;
        flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'h0;
        #1;
        stalls += int'(stall_o);
        for (int c = 1; c <= rdy; c++) begin
            @(negedge clk);
            op1_i        = ~a;
            op2_i        = b ^ 32'h5A5A_A5A5;
            div_signed_i = ~s;
            div_ready_i  = (c == rdy);
            div_result_i = (c == rdy) ? res : 64'hDEAD_BEEF_CAFE_F00D;
            #1;
            stalls += int'(stall_o);
            wes    += int'(hilo_we_o);
            if (c == 1) begin
                chk({tag, "_start"}, div_start_o, 1'b1);
                chk({tag, "_nodiscard"}, div_discard_o, 1'b0);
            end
            if (c == rdy) begin
                chk({tag, "_op1_held"}, div_op1_o, a);
                chk({tag, "_op2_held"}, div_op2_o, b);
                chk({tag, "_sign_held"}, div_signed_o, s);
            end
        end
        @(negedge clk);
        div_req_i = 1'b0; div_ready_i = 1'b0; flush_i = done_flush;
        #1;
        chk({tag, "_stall_cycles"}, stalls, rdy + 1);
        chk({tag, "_busy_no_we"}, wes, 0);
        chk({tag, "_done_we"}, hilo_we_o, !done_flush);
        chk({tag, "_done_stall"}, stall_o, 1'b0);
        chk({tag, "_done_start"}, div_start_o, 1'b0);
        chk({tag, "_hi"}, hi_o, exp_hi);
        chk({tag, "_lo"}, lo_o, exp_lo);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk({tag, "_we_one_cycle"}, hilo_we_o, 1'b0);
        chk({tag, "_lo_hold"}, lo_o, exp_lo);
    endtask

    initial begin
        int dcnt;
        int wes;
        rst = 1'b0; div_req_i = 1'b0; div_signed_i = 1'b0; op1_i = '0; op2_i = '0;
        flush_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_start", div_start_o, 1'b0);
        chk("rst_discard", div_discard_o, 1'b0);
        chk("rst_we", hilo_we_o, 1'b0);
        chk("rst_hilo", {hi_o, lo_o}, 64'h0);
        chk("rst_ops", {div_op1_o, div_op2_o}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // div_ready_i in IDLE is ignored
        @(negedge clk);
        div_ready_i = 1'b1; div_result_i = 64'h1111_1111_2222_2222;
        #1;
        chk("idle_rdy_stall", stall_o, 1'b0);
        @(negedge clk);
        div_ready_i = 1'b0;
        #1;
        chk("idle_rdy_start", div_start_o, 1'b0);
        chk("idle_rdy_we", hilo_we_o, 1'b0);
        chk("idle_rdy_lo", lo_o, 32'h0);

        // Request together with flush in IDLE is not accepted
        @(negedge clk);
        div_req_i = 1'b1; flush_i = 1'b1; op1_i = 32'd50;
        #1;
        chk("idle_flush_stall", stall_o, 1'b0);
        @(negedge clk);
        div_req_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("idle_flush_start", div_start_o, 1'b0);
        chk("idle_flush_op1", div_op1_o, 32'h0);

        // DIVU 100/7 = 14 r 2
        do_div("divu", 32'd100, 32'd7, 1'b0, 36, {32'd2, 32'd14}, 32'h2, 32'hE, 1'b0);
        // DIV -7/2 = -3 r -1
        do_div("div_s", 32'hFFFF_FFF9, 32'd2, 1'b1, 36, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        // DIVU 5/0: divider answers in cycle 4, DONE in cycle 5
        do_div("divz", 32'd5, 32'd0, 1'b0, 4, 64'h0, 32'h0, 32'h0, 1'b0);
        // DIVU 20/6 = 3 r 2 with a flush landing in DONE: captured, not written
        do_div("done_flush", 32'd20, 32'd6, 1'b0, 36, {32'd2, 32'd3}, 32'h2, 32'h3, 1'b1);

        // Flush in BUSY cycle 10
        @(negedge clk);
        div_req_i = 1'b1; op1_i = 32'd100; op2_i = 32'd7; div_signed_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            flush_i = (c == 10);
        end
        #1;
        chk("fl_stall_c10", stall_o, 1'b1);
        dcnt = 0;
        wes  = 0;
        for (int c = 11; c <= 13; c++) begin
            @(negedge clk);
            flush_i = 1'b0;
            div_req_i = (c == 13);
            op1_i = 32'd9; op2_i = 32'd3;
            div_ready_i = (c == 13);
            div_result_i = 64'h0000_0007_0000_0007;
            #1;
            dcnt += int'(div_discard_o);
            wes  += int'(hilo_we_o);
            if (c == 11) chk("fl_cancel_start", div_start_o, 1'b0);
            if (c == 13) chk("fl_cancel_req_stall", stall_o, 1'b1);
        end
        chk("fl_discard_cycles", dcnt, 3);
        chk("fl_no_we", wes, 0);
        chk("fl_lo_kept", lo_o, 32'h3);
        // DIVU 9/3 = 3 r 0 starts from the IDLE cycle right after CANCEL
        do_div("after_fl", 32'd9, 32'd3, 1'b0, 36, {32'd0, 32'd3}, 32'h0, 32'h3, 1'b0);

        // Flush coinciding with div_ready_i
        @(negedge clk);
        div_req_i = 1'b1; op1_i = 32'd7; op2_i = 32'd7; div_signed_i = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            div_ready_i  = (c == 36);
            flush_i      = (c == 36);
            div_result_i = {32'd0, 32'd1};
        end
        dcnt = 0;
        wes  = 0;
        for (int c = 37; c <= 40; c++) begin
            @(negedge clk);
            div_req_i = 1'b0; div_ready_i = 1'b0; flush_i = 1'b0;
            #1;
            dcnt += int'(div_discard_o);
            wes  += int'(hilo_we_o);
        end
        chk("frdy_discard_cycles", dcnt, 3);
        chk("frdy_no_we", wes, 0);
        chk("frdy_discard_end", div_discard_o, 1'b0);
        chk("frdy_lo_kept", lo_o, 32'h3);

        // Asynchronous reset in BUSY
        @(negedge clk);
        div_req_i = 1'b1; op1_i = 32'd100; op2_i = 32'd7; div_signed_i = 1'b1;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        #1;
        chk("rb_busy_start", div_start_o, 1'b1);
        rst = 1'b0;
        #1;
        chk("rb_stall", stall_o, 1'b0);
        chk("rb_start", div_start_o, 1'b0);
        chk("rb_sign", div_signed_o, 1'b0);
        chk("rb_ops", {div_op1_o, div_op2_o}, 64'h0);
        chk("rb_hilo", {hi_o, lo_o}, 64'h0);
        chk("rb_discard_we", {div_discard_o, hilo_we_o}, 2'b00);
        @(negedge clk);
        div_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rb_after_idle", {stall_o, div_start_o}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port div_req_i, input, 1: EX stage holds a valid DIV/DIVU instruction.
REQ-004 SHALL have port div_signed_i, input, 1: 1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have ports op1_i / op2_i, input, 32 each: dividend and divisor from EX.
REQ-006 SHALL have port flush_i, input, 1: pipeline flush or exception; cancels any division in flight.
REQ-007 SHALL have port stall_o, output, 1: stall request to the pipeline controller.
REQ-008 SHALL have port div_start_o, output, 1: start request to the divider.
REQ-009 SHALL have port div_signed_o, output, 1: signed request to the divider.
REQ-010 SHALL have port div_discard_o, output, 1: abort request to the divider.
REQ-011 SHALL have ports div_op1_o / div_op2_o, output, 32 each: latched operands to the divider.
REQ-012 SHALL have port div_result_i, input, 64: divider result, {remainder[63:32], quotient[31:0]}.
REQ-013 SHALL have port div_ready_i, input, 1: divider result valid.
REQ-014 SHALL have ports hi_o / lo_o, output, 32 each: remainder and quotient for HI/LO writeback.
REQ-015 SHALL have port hilo_we_o, output, 1: one-cycle HI/LO write strobe.

Function
REQ-016 SHALL implement an FSM with states IDLE, BUSY, DONE and CANCEL.
REQ-017 IDLE: if div_req_i=1 and flush_i=0, SHALL latch op1_i, op2_i and div_signed_i into div_op1_o, div_op2_o and div_signed_o, then enter BUSY.
REQ-018 In IDLE, div_start_o=0, div_discard_o=0 and hilo_we_o=0.
REQ-019 BUSY: div_start_o=1 (registered) and the latched operands and sign SHALL stay constant for the whole state, because the divider re-reads them at its sign-fix step.
REQ-020 BUSY with div_ready_i=1 and flush_i=0: SHALL register hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0], then enter DONE.
REQ-021 DONE lasts exactly 1 cycle: div_start_o=0, hilo_we_o=!flush_i, stall_o=0; next state IDLE.
REQ-022 hi_o and lo_o SHALL hold their value until the next capture.
REQ-023 BUSY with flush_i=1 (takes priority over div_ready_i): SHALL enter CANCEL and never assert hilo_we_o for that instruction.
REQ-024 CANCEL lasts exactly 3 cycles, counted by a 2-bit counter: div_start_o=0 and div_discard_o=1 throughout.
REQ-025 The 3-cycle CANCEL length covers a divider caught in its execute, divide-by-zero or end state; after CANCEL the FSM SHALL return to IDLE.
REQ-026 stall_o = (IDLE & div_req_i & !flush_i) | BUSY | (CANCEL & div_req_i); stall_o SHALL be combinational from state and inputs.
REQ-027 A new request SHALL NOT start before the FSM is back in IDLE; back-to-back divisions restart from the IDLE cycle after DONE.
REQ-028 A zero divisor SHALL be forwarded unchanged; the divider returns 0, so hi_o=lo_o=0.
REQ-029 Latency with the team divider: request seen in cycle 0, BUSY from cycle 1, div_ready_i from cycle 36, DONE in cycle 37; stall_o high in cycles 0-36.
REQ-030 Divide-by-zero latency: DONE in cycle 5.
REQ-031 div_ready_i while IDLE or CANCEL SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, CANCEL counter 0, all outputs 0 (including hi_o, lo_o and the operand registers), regardless of clk.
REQ-033 Reset mid-division SHALL abandon the operation; the divider is reset by the same network.

Verification
REQ-034 Unsigned: DIVU 100/7 -> stall_o high 37 cycles, then hilo_we_o one cycle with lo_o=0x0000000E and hi_o=0x00000002.
REQ-035 Signed: DIV 0xFFFFFFF9/2 -> lo_o=0xFFFFFFFD and hi_o=0xFFFFFFFF.
REQ-036 Divide by zero: DIVU 5/0 -> DONE in cycle 5, hi_o=lo_o=0, hilo_we_o=1.
REQ-037 Flush in BUSY cycle 10 -> div_discard_o high 3 cycles, no hilo_we_o; then a new DIVU 9/3 completes with lo_o=3 and hi_o=0.
REQ-038 Flush coinciding with div_ready_i -> CANCEL, no write.
REQ-039 Operands on op1_i change during BUSY -> div_op1_o unchanged, correct result.
REQ-040 rst asserted in BUSY -> all outputs 0 asynchronously.
